// File: rtl/cla_pipe.sv
// cla_pipe: pipelined N-bit carry-lookahead adder/subtractor, one W=N/S chunk per stage.
// Ports: clk/reset (sync, active-high); in_valid/in_ready + input1, input2, sub accept an op;
// out_valid/out_ready deliver result = {carry_out, sum} and signed overflow.
module cla_pipe #(
    parameter int N = 50,
    parameter int S = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   result,
    output logic         overflow
);
    localparam int W = N / S;

    // Flat sum-of-products lookahead: each carry is formed directly from g/p and cin.
    function automatic logic [W:0] cla(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W:0]   c;
        logic         pp;
        g = a & b;
        p = a ^ b;
        c = '0;
        c[0] = cin;
        for (int i = 1; i <= W; i++) begin
            pp = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                c[i] = c[i] | (g[j] & pp);
                pp = pp & p[j];
            end
            c[i] = c[i] | (pp & cin);
        end
        return {c[W], p ^ c[W-1:0]};
    endfunction

    // Stage k registers hold the full operand/sum words; chunks above k are the input skew,
    // chunks up to k the de-skewed partial sum. B is stored already inverted for subtraction.
    logic [N-1:0] a_q [S];
    logic [N-1:0] b_q [S];
    logic [N-1:0] s_q [S];
    logic [N-1:0] a_in [S];
    logic [N-1:0] b_in [S];
    logic [N-1:0] s_in [S];
    logic [N-1:0] s_d [S];
    logic [W:0]   r [S];
    logic [S-1:0] v_q, v_d, c_q, c_d, ci;
    logic         ov_q, ov_d;

    assign out_valid = v_q[S-1];
    assign in_ready  = !out_valid || out_ready;
    assign result    = {c_q[S-1], s_q[S-1]};
    assign overflow  = ov_q;

    always_comb begin
        a_in[0] = input1;
        b_in[0] = input2 ^ {N{sub}};
        s_in[0] = '0;
        ci[0]   = sub;
        v_d[0]  = in_valid;
        for (int k = 1; k < S; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            ci[k]   = c_q[k-1];
            v_d[k]  = v_q[k-1];
        end
        for (int k = 0; k < S; k++) begin
            r[k] = cla(a_in[k][k*W +: W], b_in[k][k*W +: W], ci[k]);
            s_d[k] = s_in[k];
            s_d[k][k*W +: W] = r[k][W-1:0];
            c_d[k] = r[k][W];
        end
        ov_d = (a_in[S-1][N-1] == b_in[S-1][N-1]) && (s_d[S-1][N-1] != a_in[S-1][N-1]);
    end

    // Global stall: everything holds while the output is blocked.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= '{default: '0};
            b_q  <= '{default: '0};
            s_q  <= '{default: '0};
            v_q  <= '0;
            c_q  <= '0;
            ov_q <= 1'b0;
        end else if (in_ready) begin
            a_q  <= a_in;
            b_q  <= b_in;
            s_q  <= s_d;
            v_q  <= v_d;
            c_q  <= c_d;
            ov_q <= ov_d;
        end
    end
endmodule

// File: tb/tb_cla_pipe.sv
// tb_cla_pipe: directed and streaming checks of cla_pipe at S=2, S=5 and S=1.
module tb_cla_pipe;
    localparam int N = 50;

    logic         clk = 1'b0;
    logic         reset, in_valid, sub, out_ready;
    logic [N-1:0] input1, input2;
    logic [2:0]   rdy, vld, ovf;
    logic [N:0]   r2, r5, r1;
    int           n_chk = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    cla_pipe #(.N(N), .S(2)) u_s2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .input1(input1), .input2(input2), .sub(sub), .out_valid(vld[0]),
        .out_ready(out_ready), .result(r2), .overflow(ovf[0])
    );
    cla_pipe #(.N(N), .S(5)) u_s5 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .input1(input1), .input2(input2), .sub(sub), .out_valid(vld[1]),
        .out_ready(1'b1), .result(r5), .overflow(ovf[1])
    );
    cla_pipe #(.N(N), .S(1)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
        .input1(input1), .input2(input2), .sub(sub), .out_valid(vld[2]),
        .out_ready(1'b1), .result(r1), .overflow(ovf[2])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N:0] res_of(input int i);
        return i == 0 ? r2 : (i == 1 ? r5 : r1);
    endfunction

    function automatic logic [N:0] mres(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        return s ? {a >= b, a - b} : {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic mov(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        logic [N+1:0] x;
        x = s ? {a[N-1], a[N-1], a} - {b[N-1], b[N-1], b} : {a[N-1], a[N-1], a} + {b[N-1], b[N-1], b};
        return x[N+1:N-1] != {3{x[N-1]}};
    endfunction

    task automatic run_op(input string tag, input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N:0] er, input logic eo);
        int         lat [3];
        logic [N:0] gr [3];
        logic       go [3];
        int         exp_lat [3];
        exp_lat = '{2, 5, 1};
        lat = '{0, 0, 0};
        gr  = '{default: '0};
        go  = '{default: 1'b0};
        @(negedge clk);
        in_valid = 1'b1; input1 = a; input2 = b; sub = s; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            for (int i = 0; i < 3; i++)
                if (lat[i] == 0 && vld[i]) begin
                    lat[i] = c;
                    gr[i]  = res_of(i);
                    go[i]  = ovf[i];
                end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_lat_s%0d", tag, exp_lat[i]), 64'(lat[i]), 64'(exp_lat[i]));
            chk($sformatf("%s_res_s%0d", tag, exp_lat[i]), 64'(gr[i]), 64'(er));
            chk($sformatf("%s_ov_s%0d", tag, exp_lat[i]), 64'(go[i]), 64'(eo));
        end
    endtask

    initial begin
        logic [N-1:0] na, nb;
        logic         ns, acc, stall_prev;
        logic [N:0]   held;
        logic [N:0]   qr [$];
        logic         qo [$];
        int           sent, got;
        reset = 1'b1; in_valid = 1'b0; sub = 1'b0; input1 = '0; input2 = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", 64'(vld[i]), 64'd0);
            chk("rst_res", 64'(res_of(i)), 64'd0);
            chk("rst_ov", 64'(ovf[i]), 64'd0);
            chk("rst_ready", 64'(rdy[i]), 64'd1);
        end

        run_op("add_chunk_carry", 1'b0, 50'h0000001FFFFFF, 50'h1, 51'h0000002000000, 1'b0);
        run_op("add_max", 1'b0, 50'h3FFFFFFFFFFFF, 50'h3FFFFFFFFFFFF, 51'h7FFFFFFFFFFFE, 1'b0);
        run_op("add_ovf", 1'b0, 50'h1FFFFFFFFFFFF, 50'h1, 51'h2000000000000, 1'b1);
        run_op("sub_ovf", 1'b1, 50'h2000000000000, 50'h1, 51'h5FFFFFFFFFFFF, 1'b1);
        run_op("sub_borrow", 1'b1, 50'd5, 50'd7, 51'h3FFFFFFFFFFFE, 1'b0);
        run_op("sub_pos", 1'b1, 50'd7, 50'd5, 51'h4000000000002, 1'b0);

        sent = 0; got = 0; acc = 1'b0; stall_prev = 1'b0; held = '0;
        na = N'({$urandom, $urandom}); nb = N'({$urandom, $urandom}); ns = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            if (acc) begin
                sent++;
                na = N'({$urandom, $urandom}); nb = N'({$urandom, $urandom}); ns = 1'($urandom_range(0, 1));
            end
            in_valid = sent < 8; input1 = na; input2 = nb; sub = ns;
            out_ready = !(cyc >= 4 && cyc < 7);
            #1;
            chk("stream_ready", 64'(rdy[0]), 64'(!(vld[0] && !out_ready)));
            if (stall_prev) chk("stream_hold", 64'(r2), 64'(held));
            stall_prev = vld[0] && !out_ready;
            held = r2;
            if (vld[0] && out_ready) begin
                if (qr.size() == 0) chk("stream_extra", 64'd1, 64'd0);
                else begin
                    chk("stream_res", 64'(r2), 64'(qr.pop_front()));
                    chk("stream_ov", 64'(ovf[0]), 64'(qo.pop_front()));
                end
                got++;
            end
            acc = in_valid && rdy[0];
            if (acc) begin
                qr.push_back(mres(na, nb, ns));
                qo.push_back(mov(na, nb, ns));
            end
        end
        chk("stream_count", 64'(got), 64'd8);
        chk("stream_left", 64'(qr.size()), 64'd0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("stream_dup", 64'(vld[0]), 64'd0);
        end

        @(negedge clk);
        in_valid = 1'b1; input1 = 50'd3; input2 = 50'd4; sub = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            chk("flush_valid", 64'(vld), 64'd0);
            @(negedge clk);
        end
        run_op("post_reset", 1'b0, 50'd3, 50'd4, 51'd7, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
